reset_sequencer: RTL and testbench

//  Parametrised reset sequencer for board tops: waits for NUM_LOCK clock-lock inputs and the PCIe link.

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_seq_sync.sv | 29 ++
 rtl/reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_reset_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the board-level reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_WAIT_LINK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int FAULT_CNT_W = 8;

    // Width of a counter that must hold 0..value; a zero value still gets one bit.
    function automatic int cnt_width(input int unsigned value);
        return (value < 1) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-bit flop synchroniser with asynchronous clear; each bit is an independent level.
module rst_seq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] ff;

    // NOTE: every stage is cleared by the async reset so a stale "locked" level
    // can never leak through the first cycles after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Waits for clock locks and PCIe link, then releases domain resets in ascending
// order; supervises lock/link afterwards and drops every reset together on loss.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_LOCK     = 2,
    parameter int NUM_CH       = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_STABLE  = 1024,
    parameter int REQUIRE_LINK = 1,
    parameter int LINK_TIMEOUT = 2**20,
    parameter int REL_GAP      = 16,
    parameter int FAULT_HOLD   = 256
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic [NUM_LOCK-1:0]    lock_in,
    input  logic                   link_up,
    input  logic                   soft_rst,
    output logic [NUM_CH-1:0]      rst_n_out,
    output logic                   seq_done,
    output logic [2:0]             state_o,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);

    localparam int STABLE_W  = cnt_width(LOCK_STABLE);
    localparam int TIMEOUT_W = cnt_width(LINK_TIMEOUT);
    localparam int GAP_W     = cnt_width(REL_GAP);
    localparam int HOLD_W    = cnt_width(FAULT_HOLD);

    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(LOCK_STABLE - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'((LINK_TIMEOUT > 0) ? LINK_TIMEOUT - 1 : 0);
    localparam logic [GAP_W-1:0]     GAP_LAST     = GAP_W'(REL_GAP - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(FAULT_HOLD - 1);
    localparam bit                   LINK_NEEDED  = (REQUIRE_LINK != 0);
    localparam bit                   TIMEOUT_ON   = (LINK_TIMEOUT > 0);

    logic [NUM_LOCK:0]    sync_q;
    logic [NUM_LOCK-1:0]  lock_s;
    logic                 link_s;
    logic                 lock_ok;

    state_t               state;
    logic [STABLE_W-1:0]  stable_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [HOLD_W-1:0]    hold_cnt;

    rst_seq_sync #(
        .WIDTH  (NUM_LOCK + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (sys_rst),
        .d   ({link_up, lock_in}),
        .q   (sync_q)
    );

    assign {link_s, lock_s} = sync_q;
    assign lock_ok          = &lock_s;
    assign state_o          = state;

    // NOTE: all state and outputs use non-blocking assignments so every branch
    // sees the pre-edge values and the registered outputs change together.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_WAIT_LOCK;
            rst_n_out   <= '0;
            seq_done    <= 1'b0;
            fault_cnt   <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            gap_cnt     <= '0;
            hold_cnt    <= '0;
        end else begin
            seq_done <= 1'b0;
            if (!lock_ok && state != ST_WAIT_LOCK && state != ST_FAULT) begin
                state      <= ST_WAIT_LOCK;
                rst_n_out  <= '0;
                stable_cnt <= '0;
            end else if (soft_rst) begin
                state      <= ST_WAIT_LOCK;
                rst_n_out  <= '0;
                stable_cnt <= '0;
            end else if (LINK_NEEDED && !link_s && (state == ST_RELEASE || state == ST_RUN)) begin
                state       <= ST_WAIT_LINK;
                rst_n_out   <= '0;
                timeout_cnt <= '0;
            end else begin
                case (state)
                    ST_WAIT_LOCK: begin
                        if (!lock_ok) begin
                            stable_cnt <= '0;
                        end else if (stable_cnt == STABLE_LAST) begin
                            state       <= LINK_NEEDED ? ST_WAIT_LINK : ST_RELEASE;
                            timeout_cnt <= '0;
                            gap_cnt     <= '0;
                        end else begin
                            stable_cnt <= stable_cnt + STABLE_W'(1);
                        end
                    end
                    ST_WAIT_LINK: begin
                        if (link_s) begin
                            state   <= ST_RELEASE;
                            gap_cnt <= '0;
                        end else if (TIMEOUT_ON && timeout_cnt == TIMEOUT_LAST) begin
                            state    <= ST_FAULT;
                            hold_cnt <= '0;
                            if (fault_cnt != '1) begin
                                fault_cnt <= fault_cnt + FAULT_CNT_W'(1);
                            end
                        end else begin
                            timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        // Channels release by shifting a one in from bit 0 every REL_GAP cycles.
                        if (&rst_n_out) begin
                            state    <= ST_RUN;
                            seq_done <= 1'b1;
                        end else if (gap_cnt == GAP_LAST) begin
                            gap_cnt   <= '0;
                            rst_n_out <= (rst_n_out << 1) | NUM_CH'(1);
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    ST_RUN: begin
                        seq_done <= 1'b1;
                    end
                    ST_FAULT: begin
                        rst_n_out <= '0;
                        if (hold_cnt == HOLD_LAST) begin
                            state      <= ST_WAIT_LOCK;
                            stable_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state     <= ST_WAIT_LOCK;
                        rst_n_out <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release timing, lock dip, link loss, timeout faults,
// fault-count saturation, soft and hard reset, plus a link-ignoring instance.
module tb_reset_sequencer;

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_WAIT_LINK = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic       clk;
    logic       sys_rst;
    logic [1:0] lock_in;
    logic       link_up;
    logic       soft_rst;

    logic [2:0] rst_n_out;
    logic       seq_done;
    logic [2:0] state_o;
    logic [7:0] fault_cnt;

    logic [2:0] nl_rst_n_out;
    logic       nl_seq_done;
    logic [2:0] nl_state_o;
    logic [7:0] nl_fault_cnt;

    int compared   = 0;
    int mismatched = 0;

    reset_sequencer #(
        .NUM_LOCK(2), .NUM_CH(3), .SYNC_STAGES(2), .LOCK_STABLE(16), .REQUIRE_LINK(1),
        .LINK_TIMEOUT(100), .REL_GAP(8), .FAULT_HOLD(20)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .lock_in(lock_in), .link_up(link_up), .soft_rst(soft_rst),
        .rst_n_out(rst_n_out), .seq_done(seq_done), .state_o(state_o), .fault_cnt(fault_cnt)
    );

    reset_sequencer #(
        .NUM_LOCK(2), .NUM_CH(3), .SYNC_STAGES(2), .LOCK_STABLE(16), .REQUIRE_LINK(0),
        .LINK_TIMEOUT(100), .REL_GAP(8), .FAULT_HOLD(20)
    ) dut_nolink (
        .clk(clk), .sys_rst(sys_rst), .lock_in(lock_in), .link_up(link_up), .soft_rst(soft_rst),
        .rst_n_out(nl_rst_n_out), .seq_done(nl_seq_done), .state_o(nl_state_o), .fault_cnt(nl_fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] expected, input int budget);
        int n = 0;
        while (state_o !== expected && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, state_o, expected);
    endtask

    initial begin
        sys_rst  = 1'b1;
        lock_in  = 2'b00;
        link_up  = 1'b0;
        soft_rst = 1'b0;
        tick(3);
        check("reset_rst_n", rst_n_out, 3'b000);
        check("reset_done", seq_done, 1'b0);
        check("reset_state", state_o, S_WAIT_LOCK);
        check("reset_fault_cnt", fault_cnt, 8'd0);
        sys_rst = 1'b0;
        tick(2);
        check("idle_no_lock", state_o, S_WAIT_LOCK);

        // Locks and link up together: WAIT_LINK at +18, RELEASE at +19, bits at +8/+16/+24.
        lock_in = 2'b11;
        link_up = 1'b1;
        tick(17);
        check("t1_still_wait_lock", state_o, S_WAIT_LOCK);
        tick(1);
        check("t1_wait_link", state_o, S_WAIT_LINK);
        tick(1);
        check("t1_release", state_o, S_RELEASE);
        check("t1_release_rst", rst_n_out, 3'b000);
        tick(7);
        check("t1_before_bit0", rst_n_out, 3'b000);
        tick(1);
        check("t1_bit0", rst_n_out, 3'b001);
        tick(8);
        check("t1_bit1", rst_n_out, 3'b011);
        tick(8);
        check("t1_bit2", rst_n_out, 3'b111);
        check("t1_done_late", seq_done, 1'b0);
        tick(1);
        check("t1_run", state_o, S_RUN);
        check("t1_done", seq_done, 1'b1);
        check("nolink_run", nl_state_o, S_RUN);

        // Lock loss in RUN: all resets drop exactly three edges later.
        lock_in = 2'b10;
        tick(2);
        check("t4_still_high", rst_n_out, 3'b111);
        tick(1);
        check("t4_dropped", rst_n_out, 3'b000);
        check("t4_state", state_o, S_WAIT_LOCK);
        check("t4_done", seq_done, 1'b0);

        // Relock with a 5-cycle dip on lock_in[1] at count 10: WAIT_LINK moves from +18 to +35.
        tick(3);
        lock_in = 2'b11;
        tick(12);
        lock_in = 2'b01;
        tick(5);
        lock_in = 2'b11;
        tick(1);
        check("t2_delayed", state_o, S_WAIT_LOCK);
        check("t2_no_edge_a", rst_n_out, 3'b000);
        tick(16);
        check("t2_still_wait", state_o, S_WAIT_LOCK);
        check("t2_no_edge_b", rst_n_out, 3'b000);
        tick(1);
        check("t2_wait_link", state_o, S_WAIT_LINK);
        tick(1);
        check("t2_release", state_o, S_RELEASE);
        tick(8);
        check("t2_bit0", rst_n_out, 3'b001);
        tick(17);
        check("t2_run", state_o, S_RUN);
        check("t2_all_high", rst_n_out, 3'b111);

        // Link loss in RUN: back to WAIT_LINK; the link-ignoring instance stays in RUN.
        link_up = 1'b0;
        tick(2);
        check("t5_still_high", rst_n_out, 3'b111);
        tick(1);
        check("t5_dropped", rst_n_out, 3'b000);
        check("t5_state", state_o, S_WAIT_LINK);
        check("t5_nolink_state", nl_state_o, S_RUN);
        check("t5_nolink_rst", nl_rst_n_out, 3'b111);
        link_up = 1'b1;
        tick(2);
        check("t5_wait_link", state_o, S_WAIT_LINK);
        tick(1);
        check("t5_release", state_o, S_RELEASE);
        tick(8);
        check("t5_bit0", rst_n_out, 3'b001);
        tick(16);
        check("t5_all_high", rst_n_out, 3'b111);
        tick(1);
        check("t5_run", state_o, S_RUN);

        // Soft reset pulse in RUN, then restart through RELEASE.
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        check("t6_soft_rst", rst_n_out, 3'b000);
        check("t6_soft_state", state_o, S_WAIT_LOCK);
        check("t6_soft_done", seq_done, 1'b0);
        check("t6_nolink_soft", nl_state_o, S_WAIT_LOCK);
        tick(15);
        check("t6_wait_lock", state_o, S_WAIT_LOCK);
        tick(1);
        check("t6_wait_link", state_o, S_WAIT_LINK);
        tick(1);
        check("t6_release", state_o, S_RELEASE);
        tick(16);
        check("t6_mid_release", rst_n_out, 3'b011);

        // Hard reset mid-release acts without a clock edge.
        #2 sys_rst = 1'b1;
        #1;
        check("t6_async_rst", rst_n_out, 3'b000);
        check("t6_async_state", state_o, S_WAIT_LOCK);
        check("t6_async_nolink", nl_rst_n_out, 3'b000);
        tick(2);
        sys_rst = 1'b0;
        link_up = 1'b0;

        // Link never rises: FAULT after 100 cycles in WAIT_LINK, held 20 cycles.
        tick(17);
        check("t3_wait_lock", state_o, S_WAIT_LOCK);
        tick(1);
        check("t3_wait_link", state_o, S_WAIT_LINK);
        tick(99);
        check("t3_before_timeout", state_o, S_WAIT_LINK);
        tick(1);
        check("t3_fault", state_o, S_FAULT);
        check("t3_fault_cnt1", fault_cnt, 8'd1);
        check("t3_fault_rst", rst_n_out, 3'b000);
        check("t3_nolink_run", nl_state_o, S_RUN);
        check("t3_nolink_rst", nl_rst_n_out, 3'b111);
        tick(19);
        check("t3_hold", state_o, S_FAULT);
        tick(1);
        check("t3_hold_done", state_o, S_WAIT_LOCK);
        check("t3_cnt_kept", fault_cnt, 8'd1);
        tick(15);
        check("t3_relock", state_o, S_WAIT_LOCK);
        tick(1);
        check("t3_rewait_link", state_o, S_WAIT_LINK);
        tick(100);
        check("t3_fault2", state_o, S_FAULT);
        check("t3_fault_cnt2", fault_cnt, 8'd2);

        for (int i = 3; i <= 300; i++) begin
            wait_state("t3_loop_leave", S_WAIT_LOCK, 40);
            wait_state("t3_loop_fault", S_FAULT, 200);
            if (i == 254) check("t3_cnt254", fault_cnt, 8'd254);
            if (i == 255) check("t3_cnt255", fault_cnt, 8'd255);
        end
        check("t3_saturated", fault_cnt, 8'd255);
        check("t3_sat_rst", rst_n_out, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
